// File: rtl/l1_dcache_if.sv
// Request/response bus used on both sides of the L1 data cache.
// The master raises read/write with addr/wdata; the slave answers with ready/rdata.
interface l1_dcache_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  read;
   logic                  write;
   logic                  ready;

   modport master (
      output addr, wdata, read, write,
      input  rdata, ready
   );

   modport slave (
      input  addr, wdata, read, write,
      output rdata, ready
   );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Word-granular CPU side; whole-block fills and write-backs toward L2.
module l1_dcache #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int NUM_LINES   = 16,
   parameter int BLOCK_WORDS = 16,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   l1_dcache_if.slave           cpu,
   l1_dcache_if.master          l2,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);
   localparam int INDEX_W = $clog2(NUM_LINES);
   localparam int OFF_W   = $clog2(BLOCK_WORDS);
   localparam int TAG_W   = ADDR_WIDTH - INDEX_W - OFF_W;
   localparam int BLK_W   = BLOCK_WORDS * DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE, COMPARE, WRITE_BACK, ALLOCATE
   } state_t;

   state_t state_q, state_d;

   logic [NUM_LINES-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0]     tag_q [NUM_LINES];
   logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] data_q [NUM_LINES];

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  wr_q, wr_d;
   logic                  filled_q, filled_d;
   logic                  ready_q, ready_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  l2_rd_q, l2_rd_d;
   logic                  l2_wr_q, l2_wr_d;
   logic [ADDR_WIDTH-1:0] l2_addr_q, l2_addr_d;
   logic [BLK_W-1:0]      l2_wdata_q, l2_wdata_d;
   logic [CNT_WIDTH-1:0]  hit_q, hit_d;
   logic [CNT_WIDTH-1:0]  miss_q, miss_d;
   logic                  fill_we, store_we;

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic [OFF_W-1:0]   off;
   logic               hit;

   assign idx = addr_q[OFF_W +: INDEX_W];
   assign tag = addr_q[ADDR_WIDTH-1 -: TAG_W];
   assign off = addr_q[OFF_W-1:0];
   assign hit = valid_q[idx] && (tag_q[idx] == tag);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wr_d       = wr_q;
      filled_d   = filled_q;
      ready_d    = 1'b0;
      rdata_d    = rdata_q;
      l2_rd_d    = l2_rd_q;
      l2_wr_d    = l2_wr_q;
      l2_addr_d  = l2_addr_q;
      l2_wdata_d = l2_wdata_q;
      hit_d      = hit_q;
      miss_d     = miss_q;
      fill_we    = 1'b0;
      store_we   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // the cycle carrying the completion pulse never starts a request
            if ((cpu.read || cpu.write) && !ready_q) begin
               addr_d   = cpu.addr;
               wdata_d  = cpu.wdata;
               wr_d     = cpu.write;
               filled_d = 1'b0;
               state_d  = COMPARE;
            end
         end
         COMPARE: begin
            if (hit) begin
               if (wr_q) store_we = 1'b1;
               else      rdata_d  = data_q[idx][off];
               ready_d = 1'b1;
               if (!filled_q && hit_q != '1) hit_d = hit_q + 1'b1;
               state_d = IDLE;
            end else begin
               if (miss_q != '1) miss_d = miss_q + 1'b1;
               if (valid_q[idx] && dirty_q[idx]) begin
                  l2_wr_d    = 1'b1;
                  l2_addr_d  = {tag_q[idx], idx, {OFF_W{1'b0}}};
                  l2_wdata_d = data_q[idx];
                  state_d    = WRITE_BACK;
               end else begin
                  l2_rd_d   = 1'b1;
                  l2_addr_d = {tag, idx, {OFF_W{1'b0}}};
                  state_d   = ALLOCATE;
               end
            end
         end
         WRITE_BACK: begin
            if (l2.ready) begin
               l2_wr_d   = 1'b0;
               l2_rd_d   = 1'b1;
               l2_addr_d = {tag, idx, {OFF_W{1'b0}}};
               state_d   = ALLOCATE;
            end
         end
         ALLOCATE: begin
            if (l2.ready) begin
               fill_we  = 1'b1;
               l2_rd_d  = 1'b0;
               filled_d = 1'b1;
               state_d  = COMPARE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         dirty_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         filled_q   <= 1'b0;
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         l2_rd_q    <= 1'b0;
         l2_wr_q    <= 1'b0;
         l2_addr_q  <= '0;
         l2_wdata_q <= '0;
         hit_q      <= '0;
         miss_q     <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wr_q       <= wr_d;
         filled_q   <= filled_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         l2_rd_q    <= l2_rd_d;
         l2_wr_q    <= l2_wr_d;
         l2_addr_q  <= l2_addr_d;
         l2_wdata_q <= l2_wdata_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         if (fill_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end else if (store_we) begin
            dirty_q[idx] <= 1'b1;
         end
      end
   end

   // tag and data arrays carry no reset; valid gates their use
   always_ff @(posedge clk) begin
      if (rst_n && fill_we) begin
         data_q[idx] <= l2.rdata;
         tag_q[idx]  <= tag;
      end else if (rst_n && store_we) begin
         data_q[idx][off] <= wdata_q;
      end
   end

   assign cpu.ready  = ready_q;
   assign cpu.rdata  = rdata_q;
   assign l2.read    = l2_rd_q;
   assign l2.write   = l2_wr_q;
   assign l2.addr    = l2_addr_q;
   assign l2.wdata   = l2_wdata_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
endmodule

// File: tb/tb_l1_dcache.sv
// Scoreboard bench for l1_dcache: flat-memory reference model,
// randomised traffic and an L2 responder that checks every block transfer.
module tb_l1_dcache;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int NL  = 16;
   localparam int BW  = 16;
   localparam int CW  = 16;
   localparam int BLK = DW * BW;

   typedef struct {
      bit        ld;
      bit [31:0] data;
      int        hits;
      int        misses;
   } resp_t;

   typedef struct {
      bit        wr;
      bit [31:0] addr;
   } l2x_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] hit_count, miss_count;

   int checks = 0;
   int errors = 0;
   bit hold   = 1'b0;
   bit spur   = 1'b0;

   resp_t     rq[$];
   l2x_t      lq[$];
   bit [31:0] smem [bit [31:0]];
   bit [31:0] l2m  [bit [31:0]];
   bit        mv [NL];
   bit        md [NL];
   bit [31:0] mt [NL];
   int        hit_e  = 0;
   int        miss_e = 0;

   l1_dcache_if #(.DATA_WIDTH(DW),  .ADDR_WIDTH(AW)) cpu ();
   l1_dcache_if #(.DATA_WIDTH(BLK), .ADDR_WIDTH(AW)) l2 ();

   l1_dcache #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(NL),
      .BLOCK_WORDS(BW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cpu(cpu), .l2(l2),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [BLK-1:0] act,
                        input logic [BLK-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   function automatic bit [31:0] base_word(input bit [31:0] a);
      return 32'hA000_0000 | (((a >> 4) ^ 32'h4) << 8) | (a & 32'hF);
   endfunction

   function automatic bit [31:0] l2_word(input bit [31:0] a);
      return l2m.exists(a) ? l2m[a] : base_word(a);
   endfunction

   function automatic bit [31:0] exp_word(input bit [31:0] a);
      return smem.exists(a) ? smem[a] : l2_word(a);
   endfunction

   task automatic access(input bit rd, input bit wr,
                         input bit [31:0] a, input bit [31:0] d);
      int        idx;
      int        n;
      bit [31:0] tg;
      bit        h;
      resp_t     r;
      idx = int'((a >> 4) & 32'hF);
      tg  = a >> 8;
      h   = mv[idx] && (mt[idx] == tg);
      if (h) begin
         hit_e++;
      end else begin
         miss_e++;
         if (mv[idx] && md[idx])
            lq.push_back('{1'b1, (mt[idx] << 8) | (32'(idx) << 4)});
         lq.push_back('{1'b0, a & ~32'hF});
         mv[idx] = 1'b1;
         mt[idx] = tg;
         md[idx] = 1'b0;
      end
      if (wr) begin
         smem[a] = d;
         md[idx] = 1'b1;
      end
      r.ld     = !wr;
      r.data   = exp_word(a);
      r.hits   = hit_e;
      r.misses = miss_e;
      rq.push_back(r);
      @(negedge clk);
      cpu.addr  = a;
      cpu.wdata = d;
      cpu.read  = rd;
      cpu.write = wr;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu.ready && n < 200);
      cpu.read  = 1'b0;
      cpu.write = 1'b0;
      check("cpu_done", BLK'(cpu.ready), BLK'(1));
      if (h) check("hit_latency", BLK'(n), BLK'(2));
   endtask

   initial begin : monitor
      resp_t r;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("l2_exclusive", BLK'(l2.read & l2.write), '0);
            if (cpu.ready) begin
               if (rq.size() == 0) begin
                  flag("cpu_unexpected_ready");
               end else begin
                  r = rq.pop_front();
                  if (r.ld) check("rdata", BLK'(cpu.rdata), BLK'(r.data));
                  check("hit_count", BLK'(hit_count), BLK'(r.hits));
                  check("miss_count", BLK'(miss_count), BLK'(r.misses));
               end
            end
         end
      end
   end

   initial begin : l2_side
      bit [31:0]      ba;
      bit             w;
      logic [BLK-1:0] blk;
      logic [BLK-1:0] wd;
      l2x_t           e;
      l2.ready = 1'b0;
      l2.rdata = '0;
      forever begin
         @(negedge clk);
         if (!hold && rst_n && (l2.read || l2.write)) begin
            ba = l2.addr;
            w  = l2.write;
            wd = l2.wdata;
            if (lq.size() == 0) begin
               flag("l2_unexpected_request");
            end else begin
               e = lq.pop_front();
               check("l2_kind", BLK'(w), BLK'(e.wr));
               check("l2_addr", BLK'(ba), BLK'(e.addr));
            end
            if (w) begin
               for (int k = 0; k < BW; k++)
                  blk[k*DW +: DW] = exp_word(ba + 32'(k));
               check("l2_wdata", wd, blk);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (!w) begin
               for (int k = 0; k < BW; k++)
                  blk[k*DW +: DW] = l2_word(ba + 32'(k));
               l2.rdata = blk;
            end
            l2.ready = 1'b1;
            @(negedge clk);
            l2.ready = 1'b0;
            if (w)
               for (int k = 0; k < BW; k++)
                  l2m[ba + 32'(k)] = wd[k*DW +: DW];
         end else if (spur && !hold && $urandom_range(0, 7) == 0) begin
            l2.ready = 1'b1;
            @(negedge clk);
            l2.ready = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int        n;
      int        op;
      bit [31:0] a;
      cpu.addr  = '0;
      cpu.wdata = '0;
      cpu.read  = 1'b0;
      cpu.write = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cpu_ready", BLK'(cpu.ready), '0);
      check("rst_cpu_rdata", BLK'(cpu.rdata), '0);
      check("rst_l2_read", BLK'(l2.read), '0);
      check("rst_l2_write", BLK'(l2.write), '0);
      check("rst_l2_addr", BLK'(l2.addr), '0);
      check("rst_l2_wdata", l2.wdata, '0);
      check("rst_hits", BLK'(hit_count), '0);
      check("rst_misses", BLK'(miss_count), '0);
      rst_n = 1'b1;

      access(1'b1, 1'b0, 32'h043, 32'h0);
      access(1'b1, 1'b0, 32'h045, 32'h0);
      access(1'b0, 1'b1, 32'h045, 32'hDEAD_BEEF);
      access(1'b1, 1'b0, 32'h045, 32'h0);
      access(1'b1, 1'b0, 32'h145, 32'h0);
      access(1'b1, 1'b1, 32'h2A7, 32'h1234_5678);
      access(1'b1, 1'b0, 32'h2A7, 32'h0);
      access(1'b1, 1'b0, 32'h3A0, 32'h0);

      // withhold the fill, then reset while the cache waits in ALLOCATE
      hold = 1'b1;
      @(negedge clk);
      cpu.addr = 32'h455;
      cpu.read = 1'b1;
      n = 0;
      while (!l2.read && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("alloc_reached", BLK'(l2.read), BLK'(1));
      repeat (2) @(negedge clk);
      rst_n    = 1'b0;
      cpu.read = 1'b0;
      @(negedge clk);
      check("abort_l2_read", BLK'(l2.read), '0);
      check("abort_l2_write", BLK'(l2.write), '0);
      check("abort_cpu_ready", BLK'(cpu.ready), '0);
      check("abort_hits", BLK'(hit_count), '0);
      check("abort_misses", BLK'(miss_count), '0);
      rst_n = 1'b1;
      for (int i = 0; i < NL; i++) begin
         mv[i] = 1'b0;
         md[i] = 1'b0;
      end
      hit_e  = 0;
      miss_e = 0;
      smem.delete();
      lq.delete();
      rq.delete();
      hold = 1'b0;
      access(1'b1, 1'b0, 32'h045, 32'h0);

      spur = 1'b1;
      for (int i = 0; i < 400; i++) begin
         op = int'($urandom_range(0, 3));
         a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4)
            | $urandom_range(0, 15);
         access(op != 2, op >= 2, a, $urandom);
      end
      spur = 1'b0;
      repeat (5) @(negedge clk);
      check("rq_drained", BLK'(rq.size()), '0);
      check("lq_drained", BLK'(lq.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache directly upstream of the L2 cache.
- Serves word-granular CPU loads/stores; on a miss it issues whole-block read/write transactions on the L2 block interface.
- Addresses are word addresses; a block is BLOCK_WORDS words, flattened word 0 in the LSBs.
- Hit/miss counters support the cache-hierarchy testbenches.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 32, word-address width
NUM_LINES, 16, cache lines (power of 2); INDEX_W = clog2(NUM_LINES)
BLOCK_WORDS, 16, words per block (power of 2); OFF_W = clog2(BLOCK_WORDS); TAG_W = ADDR_WIDTH-INDEX_W-OFF_W
CNT_WIDTH, 16, perf counter width

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
cpu_addr  in  ADDR_WIDTH  word address; tag=[MSB:INDEX_W+OFF_W], index=[INDEX_W+OFF_W-1:OFF_W], offset=[OFF_W-1:0]
cpu_wdata  in  DATA_WIDTH  store data
cpu_read  in  1  load request, held until cpu_ready
cpu_write  in  1  store request, held until cpu_ready
cpu_rdata  out  DATA_WIDTH  load data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
l2_addr  out  ADDR_WIDTH  block-aligned address (offset bits 0)
l2_wdata  out  BLOCK_WORDS*DATA_WIDTH  evicted block
l2_rdata  in  BLOCK_WORDS*DATA_WIDTH  fill block, sampled when l2_ready=1
l2_read  out  1  block fill request
l2_write  out  1  block write-back request
l2_ready  in  1  L2 completion pulse
hit_count  out  CNT_WIDTH  completed CPU requests that hit on first compare
miss_count  out  CNT_WIDTH  CPU requests that missed

Behaviour:
- Storage: per line valid, dirty, tag, data. Reset clears valid and dirty only.
- Reset: state IDLE. cpu_ready, cpu_rdata, l2_read, l2_write, l2_addr, l2_wdata and both counters are 0.
- Reset mid-operation aborts any transaction. Dirty data is discarded (no flush). l2_read/l2_write are low after the reset edge.
- All outputs are registered.
- FSM states: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- IDLE:
  - cpu_ready <= 0.
  - If (cpu_read|cpu_write) and cpu_ready==0: latch addr, wdata and op, then go to COMPARE. A request present in the cycle cpu_ready=1 is ignored.
  - If both cpu_read and cpu_write are asserted, the request is a write.
- COMPARE, hit (valid and tag match on the latched address):
  - Load: cpu_rdata <= word[offset].
  - Store: word[offset] <= wdata; dirty <= 1.
  - cpu_ready <= 1, then go to IDLE.
  - Hit latency: request sampled at edge E0; cpu_ready high in the cycle after E1.
  - hit_count increments only if no fill occurred for this request.
- COMPARE, miss:
  - miss_count increments.
  - If the line is valid and dirty: l2_write <= 1, l2_addr <= {stored tag, index, 0}, l2_wdata <= line, go to WRITE_BACK.
  - Otherwise: l2_read <= 1, l2_addr <= {tag, index, 0}, go to ALLOCATE.
- WRITE_BACK:
  - Hold the outputs until l2_ready=1 is sampled.
  - At that edge: l2_write <= 0, l2_read <= 1, l2_addr <= {tag, index, 0}, go to ALLOCATE.
- ALLOCATE:
  - Hold until l2_ready=1.
  - At that edge: line <= l2_rdata, tag <= tag, valid <= 1, dirty <= 0, l2_read <= 0, go to COMPARE. The re-compare hits and completes the request; a store then merges and sets dirty.
- l2_read and l2_write are never high together. Each request stays asserted until the l2_ready edge and is low for at least one cycle after it.
- l2_ready while neither request is outstanding is ignored.
- Counters saturate at all-ones. At most one increment of each counter per request.
- No cache-state change or CPU response occurs except as listed.

Test Plan:
1. Reset, then load 0x43 -> miss, l2_read=1 with l2_addr=0x40. L2 model returns word k = 0xA0000000+k after 3 cycles -> cpu_rdata=0xA0000003, miss_count=1, no l2_write.
2. Load 0x45 -> cpu_ready in the 2nd cycle after the request, cpu_rdata=0xA0000005, no L2 activity, hit_count=1.
3. Store 0x45 = 0xDEADBEEF, then load 0x45 -> 0xDEADBEEF, no L2 traffic, hit_count=3.
4. Load 0x145 (same index, tag 1):
   - first l2_write with l2_addr=0x40 and l2_wdata word5=0xDEADBEEF, word3=0xA0000003;
   - after l2_ready, l2_read with l2_addr=0x140;
   - returns fill word5;
   - miss_count=2.
5. cpu_read and cpu_write both asserted, addr 0x2A7, wdata 0x12345678, cold line -> one l2_read at 0x2A0, no l2_write. A subsequent load of 0x2A7 returns 0x12345678; evicting 0x2A7 produces an l2_write.
6. rst_n low during ALLOCATE (l2_ready withheld) -> l2_read=0 and cpu_ready=0 after the edge, counters 0. A later load of 0x45 misses with l2_addr=0x40 and no write-back.
